// File: rtl/scm_pkg.sv
// rtl/scm_pkg.sv - shared control-state definitions for the latch register files
package scm_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } scm_state_e;

endpackage

// File: rtl/cluster_clock_gating.sv
// rtl/cluster_clock_gating.sv - latch-based integrated clock gate
module cluster_clock_gating (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);

  logic en_latched;

  // Enable is captured only while the clock is low so clk_o cannot glitch.
  always_latch begin
    if (!clk_i) en_latched <= en_i | test_en_i;
  end

  assign clk_o = clk_i & en_latched;

endmodule

// File: rtl/latch_rf_write_decoder.sv
// rtl/latch_rf_write_decoder.sv - merges write ports and clear port into per-word, per-byte enables and source selects
module latch_rf_write_decoder #(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_BYTE   = 4,
  parameter int N_WRITE    = 2,
  parameter int SRC_W      = 2
) (
  input  logic [N_WRITE-1:0]                                   we,
  input  logic [N_WRITE-1:0][ADDR_WIDTH-1:0]                   addr,
  input  logic [N_WRITE-1:0][NUM_BYTE-1:0]                     be,
  input  logic                                                 clear_en,
  input  logic [ADDR_WIDTH-1:0]                                clear_ptr,
  output logic [2**ADDR_WIDTH-1:0][NUM_BYTE-1:0]               byte_en,
  output logic [2**ADDR_WIDTH-1:0][NUM_BYTE-1:0][SRC_W-1:0]    byte_src
);

  // Source index N_WRITE selects the clear value; later ports override earlier ones.
  always_comb begin
    byte_en  = '0;
    byte_src = '0;
    for (int w = 0; w < 2**ADDR_WIDTH; w++) begin
      for (int b = 0; b < NUM_BYTE; b++) begin
        if (clear_en && clear_ptr == ADDR_WIDTH'(w)) begin
          byte_en[w][b]  = 1'b1;
          byte_src[w][b] = SRC_W'(N_WRITE);
        end
        for (int p = 0; p < N_WRITE; p++) begin
          if (we[p] && addr[p] == ADDR_WIDTH'(w) && be[p][b]) begin
            byte_en[w][b]  = 1'b1;
            byte_src[w][b] = SRC_W'(p);
          end
        end
      end
    end
  end

endmodule

// File: rtl/latch_register_file_nr_mw_all.sv
// rtl/latch_register_file_nr_mw_all.sv - latch-based register file, N read / N write ports, byte enables, sequential clear
module latch_register_file_nr_mw_all
  import scm_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BYTE   = DATA_WIDTH / 8,
  parameter int N_READ     = 2,
  parameter int N_WRITE    = 2,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [N_READ-1:0]                             ReadEnable,
  input  logic [N_READ-1:0][ADDR_WIDTH-1:0]             ReadAddr,
  output logic [N_READ-1:0][DATA_WIDTH-1:0]             ReadData,
  input  logic [N_WRITE-1:0]                            WriteEnable,
  input  logic [N_WRITE-1:0][ADDR_WIDTH-1:0]            WriteAddr,
  input  logic [N_WRITE-1:0][NUM_BYTE-1:0][7:0]         WriteData,
  input  logic [N_WRITE-1:0][NUM_BYTE-1:0]              WriteBE,
  input  logic                                          ClearReq,
  output logic                                          Busy,
  output logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0]      MemContent
);

  localparam int NUM_WORDS = 2**ADDR_WIDTH;
  localparam int SRC_W     = $clog2(N_WRITE + 1);

  scm_state_e                                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]                         ptr_q, ptr_d;
  logic                                          busy;
  logic                                          clear_en;
  logic [N_WRITE-1:0]                            we_acc;
  logic [NUM_WORDS-1:0][NUM_BYTE-1:0]            byte_en;
  logic [NUM_WORDS-1:0][NUM_BYTE-1:0][SRC_W-1:0] byte_src, src_q;
  logic [N_WRITE-1:0][NUM_BYTE-1:0][7:0]         wdata_q;
  logic [N_READ-1:0][ADDR_WIDTH-1:0]             raddr_q;
  logic                                          clk_global;

  assign busy     = (state_q == CLEAR);
  assign Busy     = busy;
  assign clear_en = busy & ~rst;
  assign we_acc   = WriteEnable & {N_WRITE{~(busy | ClearReq | rst)}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (ClearReq) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + ADDR_WIDTH'(1);
        if (ptr_q == ADDR_WIDTH'(NUM_WORDS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      raddr_q <= '0;
    end else begin
      for (int p = 0; p < N_READ; p++) begin
        if (ReadEnable[p] && !busy) raddr_q[p] <= ReadAddr[p];
      end
    end
  end

  // Only enabled lanes are sampled; the latches read these flops while clk is high.
  always_ff @(posedge clk) begin
    for (int p = 0; p < N_WRITE; p++) begin
      for (int b = 0; b < NUM_BYTE; b++) begin
        if (we_acc[p] && WriteBE[p][b]) wdata_q[p][b] <= WriteData[p][b];
      end
    end
    src_q <= byte_src;
  end

  latch_rf_write_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_BYTE   (NUM_BYTE),
    .N_WRITE    (N_WRITE),
    .SRC_W      (SRC_W)
  ) i_write_decoder (
    .we        (we_acc),
    .addr      (WriteAddr),
    .be        (WriteBE),
    .clear_en  (clear_en),
    .clear_ptr (ptr_q),
    .byte_en   (byte_en),
    .byte_src  (byte_src)
  );

  cluster_clock_gating i_cg_global (
    .clk_i     (clk),
    .en_i      (|byte_en),
    .test_en_i (1'b0),
    .clk_o     (clk_global)
  );

  for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
    for (genvar b = 0; b < NUM_BYTE; b++) begin : g_byte
      logic       byte_clk;
      logic [7:0] lat_d;
      logic [7:0] lat_q;

      cluster_clock_gating i_cg (
        .clk_i     (clk_global),
        .en_i      (byte_en[w][b]),
        .test_en_i (1'b0),
        .clk_o     (byte_clk)
      );

      always_comb begin
        lat_d = CLEAR_VALUE[8*b +: 8];
        for (int p = 0; p < N_WRITE; p++) begin
          if (src_q[w][b] == SRC_W'(p)) lat_d = wdata_q[p][b];
        end
      end

      always_latch begin
        if (byte_clk) lat_q <= lat_d;
      end

      assign MemContent[w][8*b +: 8] = lat_q;
    end
  end

  always_comb begin
    for (int p = 0; p < N_READ; p++) begin
      ReadData[p] = MemContent[raddr_q[p]];
    end
  end

endmodule

// File: tb/tb_latch_register_file_nr_mw_all.sv
// tb/tb_latch_register_file_nr_mw_all.sv - directed self-checking bench for the latch register file
module tb_latch_register_file_nr_mw_all;

  localparam int          AW = 3;
  localparam logic [31:0] CV = 32'hA5A5A5A5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           ReadEnable;
  logic [1:0][AW-1:0]   ReadAddr;
  logic [1:0][31:0]     ReadData;
  logic [1:0]           WriteEnable;
  logic [1:0][AW-1:0]   WriteAddr;
  logic [1:0][3:0][7:0] WriteData;
  logic [1:0][3:0]      WriteBE;
  logic                 ClearReq;
  logic                 Busy;
  logic [7:0][31:0]     MemContent;

  int n_checks = 0;
  int n_fail   = 0;

  latch_register_file_nr_mw_all #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (32),
    .NUM_BYTE    (4),
    .N_READ      (2),
    .N_WRITE     (2),
    .CLEAR_VALUE (CV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ReadEnable  (ReadEnable),
    .ReadAddr    (ReadAddr),
    .ReadData    (ReadData),
    .WriteEnable (WriteEnable),
    .WriteAddr   (WriteAddr),
    .WriteData   (WriteData),
    .WriteBE     (WriteBE),
    .ClearReq    (ClearReq),
    .Busy        (Busy),
    .MemContent  (MemContent)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance one rising edge; return on the following falling edge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_idle();
    ReadEnable  = '0;
    ReadAddr    = '0;
    WriteEnable = '0;
    WriteAddr   = '0;
    WriteData   = '0;
    WriteBE     = '0;
    ClearReq    = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    drive_idle();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    n_checks++;
    if (Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_busy: got %b expected 1", Busy);
    end
    n = 0;
    while (Busy === 1'b1 && n < 40) begin
      n++;
      cycle();
    end
    n_checks++;
    if (n !== 8) begin
      n_fail++;
      $display("FAIL reset_busy_len: got %0d cycles expected 8", n);
    end
    for (int w = 0; w < 8; w++) begin
      n_checks++;
      if (MemContent[w] !== CV) begin
        n_fail++;
        $display("FAIL reset_word%0d: got %h expected %h", w, MemContent[w], CV);
      end
    end
    n_checks++;
    if (ReadData[0] !== CV || ReadData[1] !== CV) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h/%h expected %h", ReadData[0], ReadData[1], CV);
    end
  endtask

  task automatic test_collision();
    WriteEnable  = 2'b11;
    WriteAddr[0] = 3'd3;
    WriteAddr[1] = 3'd3;
    WriteData[0] = 32'h11111111;
    WriteData[1] = 32'h22222222;
    WriteBE[0]   = 4'b1111;
    WriteBE[1]   = 4'b1111;
    cycle();
    drive_idle();
    ReadEnable[0] = 1'b1;
    ReadAddr[0]   = 3'd3;
    cycle();
    drive_idle();
    n_checks++;
    if (ReadData[0] !== 32'h22222222) begin
      n_fail++;
      $display("FAIL collision_rdata: got %h expected 22222222", ReadData[0]);
    end
    n_checks++;
    if (MemContent[3] !== 32'h22222222) begin
      n_fail++;
      $display("FAIL collision_mem: got %h expected 22222222", MemContent[3]);
    end
  endtask

  task automatic test_byte_merge();
    WriteEnable  = 2'b11;
    WriteAddr[0] = 3'd5;
    WriteAddr[1] = 3'd5;
    WriteData[0] = 32'h0000BEEF;
    WriteData[1] = 32'hDEAD0000;
    WriteBE[0]   = 4'b0011;
    WriteBE[1]   = 4'b1100;
    ReadEnable[0] = 1'b1;
    ReadAddr[0]   = 3'd5;
    cycle();
    drive_idle();
    n_checks++;
    if (ReadData[0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL merge_rdata: got %h expected deadbeef", ReadData[0]);
    end
    WriteEnable[0] = 1'b1;
    WriteAddr[0]   = 3'd5;
    WriteData[0]   = 32'hFF77FFFF;
    WriteBE[0]     = 4'b0100;
    cycle();
    drive_idle();
    n_checks++;
    if (ReadData[0] !== 32'hDE77BEEF) begin
      n_fail++;
      $display("FAIL merge_partial: got %h expected de77beef", ReadData[0]);
    end
  endtask

  task automatic test_write_through();
    WriteEnable[0] = 1'b1;
    WriteAddr[0]   = 3'd2;
    WriteData[0]   = 32'hCAFE0001;
    WriteBE[0]     = 4'b1111;
    ReadEnable[1]  = 1'b1;
    ReadAddr[1]    = 3'd2;
    cycle();
    drive_idle();
    n_checks++;
    if (ReadData[1] !== 32'hCAFE0001) begin
      n_fail++;
      $display("FAIL write_through: got %h expected cafe0001", ReadData[1]);
    end
    n_checks++;
    if (ReadData[0] !== 32'hDE77BEEF) begin
      n_fail++;
      $display("FAIL read_hold: got %h expected de77beef", ReadData[0]);
    end
  endtask

  task automatic test_clear_precedence();
    int n;
    ClearReq       = 1'b1;
    WriteEnable[0] = 1'b1;
    WriteAddr[0]   = 3'd0;
    WriteData[0]   = 32'h12345678;
    WriteBE[0]     = 4'b1111;
    cycle();
    // Requests issued while busy must all be ignored.
    drive_idle();
    ClearReq       = 1'b1;
    WriteEnable[0] = 1'b1;
    WriteAddr[0]   = 3'd1;
    WriteData[0]   = 32'hFFFFFFFF;
    WriteBE[0]     = 4'b1111;
    ReadEnable[0]  = 1'b1;
    ReadAddr[0]    = 3'd7;
    n_checks++;
    if (MemContent[0] === 32'h12345678) begin
      n_fail++;
      $display("FAIL clear_drop_write: got %h expected not 12345678", MemContent[0]);
    end
    n = 0;
    while (Busy === 1'b1 && n < 40) begin
      n++;
      cycle();
      if (n == 1) drive_idle();
    end
    n_checks++;
    if (n !== 8) begin
      n_fail++;
      $display("FAIL clear_busy_len: got %0d cycles expected 8", n);
    end
    n_checks++;
    if (MemContent[0] !== CV || MemContent[1] !== CV || MemContent[5] !== CV) begin
      n_fail++;
      $display("FAIL clear_words: got %h/%h/%h expected %h", MemContent[0], MemContent[1], MemContent[5], CV);
    end
    WriteEnable[1] = 1'b1;
    WriteAddr[1]   = 3'd7;
    WriteData[1]   = 32'h77777777;
    WriteBE[1]     = 4'b1111;
    cycle();
    drive_idle();
    n_checks++;
    if (ReadData[0] !== CV || MemContent[7] !== 32'h77777777) begin
      n_fail++;
      $display("FAIL clear_addr_held: got rd %h mem7 %h expected %h 77777777", ReadData[0], MemContent[7], CV);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    WriteEnable[0] = 1'b1;
    WriteAddr[0]   = 3'd6;
    WriteData[0]   = 32'h66666666;
    WriteBE[0]     = 4'b1111;
    ReadEnable[1]  = 1'b1;
    ReadAddr[1]    = 3'd6;
    cycle();
    drive_idle();
    n_checks++;
    if (ReadData[1] !== 32'h66666666) begin
      n_fail++;
      $display("FAIL midclr_setup: got %h expected 66666666", ReadData[1]);
    end
    ClearReq = 1'b1;
    cycle();
    ClearReq = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    n_checks++;
    if (Busy !== 1'b1 || MemContent[3] !== CV || MemContent[6] !== 32'h66666666) begin
      n_fail++;
      $display("FAIL midclr_progress: got busy %b mem3 %h mem6 %h expected 1 %h 66666666", Busy, MemContent[3], MemContent[6], CV);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n_checks++;
    if (ReadData[1] !== CV || MemContent[6] !== 32'h66666666) begin
      n_fail++;
      $display("FAIL midclr_raddr_reset: got rd1 %h mem6 %h expected %h 66666666", ReadData[1], MemContent[6], CV);
    end
    n = 0;
    while (Busy === 1'b1 && n < 40) begin
      n++;
      cycle();
    end
    n_checks++;
    if (n !== 8) begin
      n_fail++;
      $display("FAIL midclr_busy_len: got %0d cycles expected 8", n);
    end
    n_checks++;
    if (MemContent[6] !== CV || MemContent[7] !== CV) begin
      n_fail++;
      $display("FAIL midclr_words: got %h/%h expected %h", MemContent[6], MemContent[7], CV);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_collision();
    test_byte_merge();
    test_write_through();
    test_clear_precedence();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
